// File: rtl/ram_reader_pkg.sv
// Shared memory-unit definitions: default RAM8 geometry and the reader state encoding.
package ram_reader_pkg;

  localparam int unsigned RR_ADDR_WIDTH = 3;
  localparam int unsigned RR_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_reader_cursor.sv
// Read cursor: current memory address plus count of words still to fetch.
// The address wraps modulo 2^ADDR_WIDTH; a requested count above the memory
// size is clamped so a burst never revisits a word.
module ram_reader_cursor
  import ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RR_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_STEP   = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]   count_sat;

  // Clamp the requested length to the memory size.
  always_comb begin
    count_sat = count_i;
    if (count_i > FULL_COUNT) begin
      count_sat = FULL_COUNT;
    end
  end

  // Load takes priority over advance; otherwise hold.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      addr_d      = base_i;
      remaining_d = count_sat;
    end else if (advance_i) begin
      addr_d      = addr_q + ADDR_STEP;
      remaining_d = remaining_q - REM_STEP;
    end
  end

  // Cursor registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remaining_q == '0);

endmodule

// File: rtl/ram_reader.sv
// Sequential RAM reader: walks a wrapping address range of a RAM8-style memory
// and streams each word on a VALID/READY interface, pulsing DONE at the end.
// The memory read port is combinational, so the word at the cursor is captured
// into the output register in the same edge that advances the cursor.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RR_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic                  mem_load_o,
  output logic [DATA_WIDTH-1:0] mem_in_o,
  input  logic [DATA_WIDTH-1:0] mem_out_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  cursor_load;
  logic                  cursor_advance;
  logic                  cursor_last;

  ram_reader_cursor #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cursor (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (cursor_load),
    .advance_i(cursor_advance),
    .base_i   (base_i),
    .count_i  (count_i),
    .addr_o   (mem_address_o),
    .last_o   (cursor_last)
  );

  // Next-state, cursor control and output-register update.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    valid_d        = valid_q;
    cursor_load    = 1'b0;
    cursor_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            cursor_load = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FETCH: begin
        data_d         = mem_out_i;
        valid_d        = 1'b1;
        cursor_advance = 1'b1;
        state_d        = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Without READY everything holds so DATA/VALID stay stable.
        if (ready_i) begin
          if (!cursor_last) begin
            data_d         = mem_out_i;
            cursor_advance = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_FINISH);
  assign mem_load_o = 1'b0;
  assign mem_in_o   = '0;

endmodule

// File: tb/tb_ram_reader.sv
// Directed testbench for ram_reader against a small combinational RAM8 model.
module tb_ram_reader;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [AW-1:0] mem_address;
  logic          mem_load;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:7];

  int errors = 0;
  int checks = 0;

  // Results of the most recent burst.
  logic [DW-1:0] got_q[$];
  int got_done_cnt;
  int got_done_cyc;
  int got_valid_cycles;
  int got_first_valid;
  int got_busy_cycles;
  int got_hold_bad;
  int got_load_bad;

  ram_reader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .base_i       (base),
    .count_i      (count),
    .mem_address_o(mem_address),
    .mem_load_o   (mem_load),
    .mem_in_o     (mem_in),
    .mem_out_i    (mem_out),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_out = mem[mem_address];

  // Runs one burst; READY in cycle c (c = edges since START) is ready_pat[c].
  // If busy_cyc > 0 a second START (BASE=4, COUNT=1) is driven in that cycle.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n,
                           input logic [31:0] ready_pat, input int busy_cyc);
    logic          prev_valid;
    logic          prev_ready;
    logic [DW-1:0] prev_data;
    got_q.delete();
    got_done_cnt = 0; got_done_cyc = -1; got_valid_cycles = 0;
    got_first_valid = -1; got_busy_cycles = 0; got_hold_bad = 0; got_load_bad = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    start = 1'b1; base = b; count = n; ready = ready_pat[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      ready = ready_pat[cyc % 32];
      if (cyc == busy_cyc) begin
        start = 1'b1; base = 3'd4; count = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (valid) begin
        got_valid_cycles++;
        if (got_first_valid < 0) got_first_valid = cyc;
        if (ready) got_q.push_back(data);
      end
      if (prev_valid && !prev_ready && (!valid || data !== prev_data)) got_hold_bad++;
      if (busy) got_busy_cycles++;
      if (mem_load !== 1'b0 || mem_in !== '0) got_load_bad++;
      if (done) begin
        got_done_cnt++;
        got_done_cyc = cyc;
      end
      prev_valid = valid; prev_ready = ready; prev_data = data;
      @(posedge clk); #1;
      if (got_done_cnt != 0) break;
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base = '0; count = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || data !== '0 || busy !== 1'b0 || done !== 1'b0 || mem_address !== '0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b data=%h busy=%b done=%b addr=%0d, required all zero",
               valid, data, busy, done, mem_address);
    end
    checks++;
    if (mem_load !== 1'b0 || mem_in !== '0) begin
      errors++;
      $display("FAIL reset_mem_write: load=%b in=%h, required 0/0000", mem_load, mem_in);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b valid=%b done=%b, required 0/0/0", busy, valid, done);
    end
    $display("test_reset: done");
  endtask

  task automatic test_linear();
    logic [DW-1:0] w;
    run_burst(3'd0, 4'd8, 32'hFFFF_FFFF, 0);
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL linear_count: got %0d words, required 8", got_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (w !== DW'(16'h1000 + i)) begin
        errors++;
        $display("FAIL linear_word%0d: got %h, required %h", i, w, 16'h1000 + i);
      end
    end
    checks++;
    if (got_first_valid != 2 || got_valid_cycles != 8) begin
      errors++;
      $display("FAIL linear_timing: first valid cycle %0d, valid cycles %0d, required 2 and 8",
               got_first_valid, got_valid_cycles);
    end
    checks++;
    if (got_done_cnt != 1 || got_done_cyc != 10) begin
      errors++;
      $display("FAIL linear_done: done pulses %0d at cycle %0d, required 1 at 10", got_done_cnt, got_done_cyc);
    end
    checks++;
    if (busy !== 1'b0 || got_busy_cycles != 10) begin
      errors++;
      $display("FAIL linear_busy: busy=%b after, busy cycles %0d, required 0 and 10", busy, got_busy_cycles);
    end
    checks++;
    if (got_load_bad != 0) begin
      errors++;
      $display("FAIL linear_no_write: %0d cycles with write activity, required 0", got_load_bad);
    end
    $display("test_linear: %0d words", got_q.size());
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_w [4];
    logic [DW-1:0] w;
    exp_w[0] = 16'h1006; exp_w[1] = 16'h1007; exp_w[2] = 16'h1000; exp_w[3] = 16'h1001;
    run_burst(3'd6, 4'd4, 32'hFFFF_FFFF, 0);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (w !== exp_w[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: got %h, required %h", i, w, exp_w[i]);
      end
    end
    checks++;
    if (mem_address !== 3'd2) begin
      errors++;
      $display("FAIL wrap_address: final address %0d, required 2", mem_address);
    end
    checks++;
    if (got_done_cnt != 1 || got_done_cyc != 6 || got_load_bad != 0) begin
      errors++;
      $display("FAIL wrap_done: done %0d at cycle %0d, write cycles %0d, required 1 at 6, 0",
               got_done_cnt, got_done_cyc, got_load_bad);
    end
    $display("test_wrap: %0d words", got_q.size());
  endtask

  task automatic test_stall();
    logic [DW-1:0] w;
    // READY per cycle 1..7 = 1,0,0,1,0,1,1
    run_burst(3'd2, 4'd3, 32'hFFFF_FFD2, 0);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL stall_count: got %0d words, required 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (w !== DW'(16'h1002 + i)) begin
        errors++;
        $display("FAIL stall_word%0d: got %h, required %h", i, w, 16'h1002 + i);
      end
    end
    checks++;
    if (got_hold_bad != 0 || got_valid_cycles != 6) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable stall cycles, %0d valid cycles, required 0 and 6",
               got_hold_bad, got_valid_cycles);
    end
    checks++;
    if (got_done_cnt != 1 || got_done_cyc != 8 || mem_address !== 3'd5) begin
      errors++;
      $display("FAIL stall_done: done %0d at cycle %0d, address %0d, required 1 at 8, 5",
               got_done_cnt, got_done_cyc, mem_address);
    end
    $display("test_stall: %0d words", got_q.size());
  endtask

  task automatic test_zero_and_sat();
    logic [DW-1:0] w;
    run_burst(3'd3, 4'd0, 32'hFFFF_FFFF, 0);
    checks++;
    if (got_valid_cycles != 0 || got_done_cnt != 1 || got_done_cyc != 1 || got_busy_cycles != 1) begin
      errors++;
      $display("FAIL zero_count: valid cycles %0d, done %0d at cycle %0d, busy cycles %0d, required 0, 1 at 1, 1",
               got_valid_cycles, got_done_cnt, got_done_cyc, got_busy_cycles);
    end
    $display("test_zero: valid cycles %0d", got_valid_cycles);
    run_burst(3'd0, 4'd15, 32'hFFFF_FFFF, 0);
    checks++;
    if (got_q.size() != 8 || got_done_cyc != 10) begin
      errors++;
      $display("FAIL sat_count: got %0d words, done cycle %0d, required 8 and 10", got_q.size(), got_done_cyc);
    end
    w = (got_q.size() == 8) ? got_q[7] : 'x;
    checks++;
    if (w !== 16'h1007) begin
      errors++;
      $display("FAIL sat_last_word: got %h, required 1007", w);
    end
    $display("test_saturate: %0d words", got_q.size());
  endtask

  task automatic test_reset_mid();
    int words;
    int dones;
    words = 0; dones = 0;
    start = 1'b1; base = 3'd0; count = 4'd8; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (valid && ready) words++;
      if (done) dones++;
      @(posedge clk); #1;
    end
    // Two words consumed at edges 2 and 3; reset lands mid-cycle.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (words != 2) begin
      errors++;
      $display("FAIL rstmid_words_before: %0d words, required 2", words);
    end
    checks++;
    if (valid !== 1'b0 || data !== '0 || mem_address !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b data=%h addr=%0d busy=%b, required 0/0000/0/0",
               valid, data, mem_address, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    if (done) dones++;
    @(posedge clk); #1;
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: %0d done pulses, required 0", dones);
    end
    run_burst(3'd5, 4'd1, 32'hFFFF_FFFF, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h1005 || got_done_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_restart: %0d words first %h, done %0d, required 1 word 1005, done 1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx, got_done_cnt);
    end
    $display("test_reset_mid: restart %0d words", got_q.size());
  endtask

  task automatic test_start_busy();
    logic [DW-1:0] w;
    int extra_busy;
    run_burst(3'd0, 4'd3, 32'hFFFF_FFFF, 3);
    checks++;
    if (got_q.size() != 3 || got_done_cnt != 1 || got_done_cyc != 5) begin
      errors++;
      $display("FAIL busy_start_burst: %0d words, done %0d at cycle %0d, required 3, 1 at 5",
               got_q.size(), got_done_cnt, got_done_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      w = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (w !== DW'(16'h1000 + i)) begin
        errors++;
        $display("FAIL busy_start_word%0d: got %h, required %h", i, w, 16'h1000 + i);
      end
    end
    extra_busy = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busy || valid || done) extra_busy++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra_busy != 0 || got_load_bad != 0) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d active cycles after burst, %0d write cycles, required 0 and 0",
               extra_busy, got_load_bad);
    end
    $display("test_start_busy: %0d words", got_q.size());
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = DW'(16'h1000 + i);
    test_reset();
    test_linear();
    test_wrap();
    test_stall();
    test_zero_and_sat();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
